// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam int FLAG_N = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage

// File: rtl/alu.sv
// Team 4-bit ALU: 5-bit result (bit 4 = carry/borrow) and N/Z/C/V flags.
module alu
    import alu_arb_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [1:0] op,
    output logic [4:0] result,
    output logic [3:0] flags
);

    logic ovf;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = {1'b0, a} + {1'b0, b};
                ovf    = (a[3] == b[3]) && (result[3] != a[3]);
            end
            OP_SUB: begin
                result = {1'b0, a} - {1'b0, b};
                ovf    = (a[3] != b[3]) && (result[3] != a[3]);
            end
            OP_AND: result = {1'b0, a & b};
            default: result = {1'b0, a | b};
        endcase

        flags         = '0;
        flags[FLAG_N] = result[3];
        flags[FLAG_Z] = (result == 5'd0);
        flags[FLAG_C] = result[4];
        flags[FLAG_V] = ovf;
    end

endmodule

// File: rtl/alu_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid index after last_grant, modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_req
);

    localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);

    logic [ID_W:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any_req  = 1'b0;
        idx      = '0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = {1'b0, last_grant} + (ID_W+1)'(off);
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!any_req && req_valid[idx[ID_W-1:0]]) begin
                any_req                 = 1'b1;
                grant[idx[ID_W-1:0]]    = 1'b1;
                grant_id                = idx[ID_W-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters.
// Define ALU_ARB_STATS_EN to add per-requester saturating grant counters (grant_count).
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*4-1:0]   req_a,
    input  logic [NUM_REQ*4-1:0]   req_b,
    input  logic [NUM_REQ*2-1:0]   req_op,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [4:0]             resp_result,
    output logic [3:0]             resp_flags,
    output logic                   busy
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*8-1:0]   grant_count
`endif
);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    last_grant;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               any_req;
    logic               accept;

    logic [3:0]         a_q, b_q;
    logic [1:0]         op_q;
    logic [ID_W-1:0]    id_q;
    logic [4:0]         alu_result;
    logic [3:0]         alu_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id),
        .any_req    (any_req)
    );

    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Gated by reset so no handshake is offered while reset is held.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !reset) begin
            req_ready = grant;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= ID_W'(NUM_REQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            id_q        <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q        <= req_a[{grant_id, 2'b00} +: 4];
                b_q        <= req_b[{grant_id, 2'b00} +: 4];
                op_q       <= req_op[{grant_id, 1'b0} +: 2];
                id_q       <= grant_id;
                last_grant <= grant_id;
            end
            if (state == EXEC) begin
                resp_result <= alu_result;
                resp_flags  <= alu_flags;
                resp_id     <= id_q;
                resp_valid  <= 1'b1;
            end else if (state == RESP && resp_ready) begin
                resp_valid  <= 1'b0;
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt [NUM_REQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (accept && grant[i] && cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        grant_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_count[i*8 +: 8] = cnt[i];
        end
    end
`endif

endmodule
